// File: rtl/bcd_seg_converter.sv
// Serial double-dabble binary-to-BCD converter with 7-segment decode.
// Optional leading-zero blanking: define BCD_SEG_BLANK_LZ_EN.
module bcd_seg_converter #(
  parameter int IN_WIDTH = 10,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in,
  output logic                  in_ready,
  output logic [7*DIGITS-1:0]   out,
  output logic                  out_valid,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IN_WIDTH-1:0] r_val;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_bcd;
  logic                r_acc;
  logic [BW-1:0]       w_adj;
  logic [BW-1:0]       w_shift;
  logic [7*DIGITS-1:0] w_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign in_ready = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_next = S_CONVERT;
      S_CONVERT: if (r_cnt == CW'(IN_WIDTH - 1)) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // MSB of w_adj falls off the top digit: that is the overflow carry
  assign w_shift = {w_adj[BW-2:0], r_val[IN_WIDTH-1]};

  always_comb begin
    w_seg = '1;
`ifdef BCD_SEG_BLANK_LZ_EN
    begin
      logic v_seen;
      v_seen = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
        v_seen = v_seen | (r_bcd[4*k +: 4] != 4'd0);
        if (v_seen || k == 0)
          w_seg[7*k +: 7] = seg7(r_bcd[4*k +: 4]);
        else
          w_seg[7*k +: 7] = 7'h7F;
      end
    end
`else
    for (int k = 0; k < DIGITS; k++)
      w_seg[7*k +: 7] = seg7(r_bcd[4*k +: 4]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val     <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_acc     <= 1'b0;
      out       <= {DIGITS{7'h7F}};
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_val <= in;
            r_cnt <= '0;
            r_bcd <= '0;
            r_acc <= 1'b0;
          end
        end
        S_CONVERT: begin
          r_val <= r_val << 1;
          r_bcd <= w_shift;
          r_acc <= r_acc | w_adj[BW-1];
          r_cnt <= r_cnt + CW'(1);
        end
        S_DONE: begin
          out       <= w_seg;
          overflow  <= r_acc;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seg_converter.sv
// Bench for bcd_seg_converter: vector table, hand sequences, random vs model.
// Expectations follow BCD_SEG_BLANK_LZ_EN when it is defined.
module tb_bcd_seg_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv10 = 1'b0, iv14 = 1'b0;
  logic [9:0]  in10 = '0;
  logic [13:0] in14 = '0;
  logic        rdy10, rdy14, ov10, ov14, ovf10, ovf14;
  logic [27:0] out10, out14;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  bcd_seg_converter #(.IN_WIDTH(10), .DIGITS(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in(in10),
    .in_ready(rdy10), .out(out10), .out_valid(ov10), .overflow(ovf10)
  );

  bcd_seg_converter #(.IN_WIDTH(14), .DIGITS(4)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv14), .in(in14),
    .in_ready(rdy14), .out(out14), .out_valid(ov14), .overflow(ovf14)
  );

  typedef struct {
    bit          wide;
    int unsigned val;
    logic [27:0] eo_off;
    logic [27:0] eo_on;
    logic        eovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", n, got, exp);
    end
  endtask

  function automatic logic [27:0] model(input int unsigned v);
    logic [27:0] r;
    int unsigned m, p, d;
    bit seen;
    m = v % 10000;
    p = 1000;
    seen = 1'b0;
    r = '0;
    for (int k = 3; k >= 0; k--) begin
      d = (m / p) % 10;
      p = p / 10;
      seen = seen || (d != 0);
`ifdef BCD_SEG_BLANK_LZ_EN
      if (!seen && k != 0) r[7*k +: 7] = 7'h7F;
      else                 r[7*k +: 7] = SEG[d];
`else
      r[7*k +: 7] = SEG[d];
`endif
    end
    return r;
  endfunction

  task automatic run(input bit wide, input int unsigned v,
                     output logic [27:0] o, output logic ovf);
    int e;
    bit rdy_bad;
    @(negedge clk);
    if (wide) begin in14 = v[13:0]; iv14 = 1'b1; end
    else      begin in10 = v[9:0];  iv10 = 1'b1; end
    @(negedge clk);
    iv10 = 1'b0;
    iv14 = 1'b0;
    e = 0;
    rdy_bad = 1'b0;
    while (!(wide ? ov14 : ov10) && e < 60) begin
      if (wide ? rdy14 : rdy10) rdy_bad = 1'b1;
      @(negedge clk);
      e++;
    end
    chk("latency", e, wide ? 15 : 11);
    chk("in_ready_busy", rdy_bad, 0);
    o   = wide ? out14 : out10;
    ovf = wide ? ovf14 : ovf10;
    @(negedge clk);
    chk("pulse_width", wide ? ov14 : ov10, 0);
    chk("out_hold", wide ? out14 : out10, o);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [27:0] o, exp;
    logic ovf;
    int e;
    bit seen;
    int unsigned v;

    tbl.push_back('{0, 0,    {7'h40,7'h40,7'h40,7'h40}, {7'h7F,7'h7F,7'h7F,7'h40}, 0});
    tbl.push_back('{0, 1023, {7'h79,7'h40,7'h24,7'h30}, {7'h79,7'h40,7'h24,7'h30}, 0});
    tbl.push_back('{0, 5,    {7'h40,7'h40,7'h40,7'h12}, {7'h7F,7'h7F,7'h7F,7'h12}, 0});
    tbl.push_back('{0, 987,  {7'h40,7'h10,7'h00,7'h78}, {7'h7F,7'h10,7'h00,7'h78}, 0});
    tbl.push_back('{0, 1000, {7'h79,7'h40,7'h40,7'h40}, {7'h79,7'h40,7'h40,7'h40}, 0});
    tbl.push_back('{0, 609,  {7'h40,7'h02,7'h40,7'h10}, {7'h7F,7'h02,7'h40,7'h10}, 0});
    tbl.push_back('{1, 12345,{7'h24,7'h30,7'h19,7'h12}, {7'h24,7'h30,7'h19,7'h12}, 1});
    tbl.push_back('{1, 9999, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}, 0});
    tbl.push_back('{1, 10000,{7'h40,7'h40,7'h40,7'h40}, {7'h7F,7'h7F,7'h7F,7'h40}, 1});
    tbl.push_back('{1, 16383,{7'h02,7'h30,7'h00,7'h30}, {7'h02,7'h30,7'h00,7'h30}, 1});

    // reset state
    #12;
    chk("rst_out", out10, {4{7'h7F}});
    chk("rst_valid", ov10, 0);
    chk("rst_ready", rdy10, 1);
    chk("rst_ovf", ovf14, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run(tbl[i].wide, tbl[i].val, o, ovf);
`ifdef BCD_SEG_BLANK_LZ_EN
      exp = tbl[i].eo_on;
`else
      exp = tbl[i].eo_off;
`endif
      chk($sformatf("tbl_out[%0d]", tbl[i].val), o, exp);
      chk($sformatf("tbl_ovf[%0d]", tbl[i].val), ovf, tbl[i].eovf);
    end

    // overflow holds between completions
    repeat (4) @(negedge clk);
    chk("ovf_hold", ovf14, 1);

    // back-to-back with in_valid held high
    @(negedge clk);
    in10 = 10'd5;
    iv10 = 1'b1;
    @(negedge clk);
    in10 = 10'd987;
    e = 0;
    while (!ov10 && e < 60) begin @(negedge clk); e++; end
    chk("b2b_lat1", e, 11);
    chk("b2b_out1", out10, model(5));
    chk("b2b_idle", rdy10, 1);
    @(negedge clk);
    chk("b2b_accept2", rdy10, 0);
    iv10 = 1'b0;
    e = 0;
    while (!ov10 && e < 60) begin @(negedge clk); e++; end
    chk("b2b_lat2", e, 11);
    chk("b2b_out2", out10, model(987));
    repeat (5) @(negedge clk);
    chk("b2b_hold", out10, model(987));
    chk("b2b_nopulse", ov10, 0);

    // abort with reset mid-conversion
    @(negedge clk);
    in10 = 10'd512;
    iv10 = 1'b1;
    @(negedge clk);
    iv10 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out", out10, {4{7'h7F}});
    chk("abort_valid", ov10, 0);
    chk("abort_ready", rdy10, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov10) seen = 1'b1;
    end
    chk("abort_nopulse", seen, 0);
    run(0, 42, o, ovf);
`ifdef BCD_SEG_BLANK_LZ_EN
    chk("after_abort", o, {7'h7F,7'h7F,7'h19,7'h24});
`else
    chk("after_abort", o, {7'h40,7'h40,7'h19,7'h24});
`endif
    chk("after_abort_ovf", ovf, 0);

    // random against the reference model
    for (int i = 0; i < 25; i++) begin
      v = $urandom_range(0, 1023);
      run(0, v, o, ovf);
      chk($sformatf("rnd10_out[%0d]", v), o, model(v));
      chk($sformatf("rnd10_ovf[%0d]", v), ovf, 0);
      v = $urandom_range(0, 16383);
      run(1, v, o, ovf);
      chk($sformatf("rnd14_out[%0d]", v), o, model(v));
      chk($sformatf("rnd14_ovf[%0d]", v), ovf, v >= 10000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_seg_converter.md
BCD_SEG_CONVERTER -- requirements
Module: bcd_seg_converter

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 10, meaning binary input width (legal 1..32).
REQ-002 SHALL have parameter DIGITS, default 4, meaning number of decimal digits/displays (legal 1..10).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  source presents a value on in.
REQ-006 SHALL have port in  input  IN_WIDTH  unsigned binary value.
REQ-007 SHALL have port in_ready  output  1  block can accept a value (high only in IDLE).
REQ-008 SHALL have port out  output  7*DIGITS  segment patterns; digit k (10^k place) in bits [7k+6:7k].
REQ-009 SHALL have port out_valid  output  1  one-cycle pulse when out updates.
REQ-010 SHALL have port overflow  output  1  last completed value was >= 10^DIGITS.

Function
REQ-011 SHALL implement FSM IDLE -> CONVERT -> DONE -> IDLE.
REQ-012 Acceptance: in_valid & in_ready at rising edge E0; in captured, shift counter cleared, BCD register cleared, overflow accumulator cleared, state CONVERT.
REQ-013 CONVERT: edges E1..E_IN_WIDTH each perform one double-dabble step (add 3 to every BCD digit >= 5, then shift left one bit, MSB of captured value entering BCD LSB); after E_IN_WIDTH state DONE.
REQ-014 Bit shifted out of top BCD digit SHALL set the overflow accumulator (sticky within the conversion); digits retained are value mod 10^DIGITS.
REQ-015 DONE: edge E_(IN_WIDTH+1) registers decoded patterns into out, accumulator into overflow, sets out_valid for exactly that cycle, state IDLE.
REQ-016 Latency: out_valid high in the cycle following edge IN_WIDTH+1 after acceptance; max throughput one value per IN_WIDTH+2 cycles.
REQ-017 in and in_valid ignored outside IDLE; in_ready low in CONVERT and DONE.
REQ-018 out and overflow SHALL hold between completions.
REQ-019 Segment code active-low, bit0=a..bit6=g: 0=0x40,1=0x79,2=0x24,3=0x30,4=0x19,5=0x12,6=0x02,7=0x78,8=0x00,9=0x10, blank=0x7F.
REQ-020 BCD digits >9 SHALL not occur; decoder default output blank.

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, in_ready 1, out all 0x7F, out_valid 0, overflow 0, counter and BCD register 0.
REQ-022 Reset during CONVERT/DONE SHALL abort; no out_valid pulse for the aborted value.

Configuration
REQ-023 Macro BCD_SEG_BLANK_LZ_EN defined: digits above the most significant nonzero digit SHALL output 0x7F; digit 0 always shown.
REQ-024 BCD_SEG_BLANK_LZ_EN undefined: all DIGITS positions SHALL show their digit, including leading zeros.

Verification (IN_WIDTH=10, DIGITS=4 unless stated; out listed digit3..digit0)
REQ-025 in=0 accepted -> out_valid pulse after 11 edges; out=40,40,40,40 (macro off) / 7F,7F,7F,40 (macro on); overflow 0.
REQ-026 in=1023 -> out=79,40,24,30; overflow 0; in_ready low for the 11 cycles after acceptance.
REQ-027 IN_WIDTH=14, in=12345 -> out=24,30,19,12 (2345); overflow 1.
REQ-028 in_valid held high with 5 then 987 -> second acceptance only in IDLE cycle after first out_valid; pulses show 5 then 987; out holds 987 afterwards.
REQ-029 in=512 accepted, rst_n pulsed low after 5th shift -> out all 7F, out_valid 0 at once, no later pulse; then in=42 -> out=40,40,19,24 (macro off).
